dmem_dma: RTL and testbench
===========================

DMEM_DMA -- requirements
Module: dmem_dma

Interface
REQ-001 Parameter DEPTH, default 32: number of data-memory words; legal addresses are 0..DEPTH-1.
REQ-002 Parameter LEN_W, default 6: width of Length; must hold the value DEPTH.
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RST  in  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 Start  in  1  request pulse, sampled only in IDLE.
REQ-006 Mode  in  1  0 = copy, 1 = fill.
REQ-007 SrcAddr  in  8  copy source base address (ignored in fill mode).
REQ-008 DstAddr  in  8  destination base address.
REQ-009 Length  in  LEN_W  number of bytes to transfer.
REQ-010 FillValue  in  8  byte written in fill mode.
REQ-011 Busy  out  1  high in every state except IDLE.
REQ-012 Done  out  1  one-cycle pulse when a transfer completes.
REQ-013 Error  out  1  one-cycle pulse when a request is rejected.
REQ-014 Address  out  8  data-memory address.
REQ-015 writeData  out  8  data-memory write data.
REQ-016 readData  in  8  data-memory read data, combinational from Address while MemRead=1.
REQ-017 MemRead  out  1  data-memory read enable.
REQ-018 MemWrite  out  1  data-memory write enable; the memory commits the write at posedge CLK.

Function
REQ-019 States: IDLE, READ, WRITE, FIN.
REQ-020 In IDLE with Start=1, the block latches SrcAddr, DstAddr, Length, Mode and FillValue, and clears the byte index i.
REQ-021 On Start, if SrcAddr+Length>DEPTH (copy mode only) or DstAddr+Length>DEPTH, the check uses 9-bit arithmetic, Error pulses in the next cycle, no memory access occurs, and the block stays in IDLE.
REQ-022 On an accepted Start with Length=0, the next state is FIN and no memory access occurs.
REQ-023 On an accepted Start in copy mode with Length>0, the next state is READ.
REQ-024 On an accepted Start in fill mode with Length>0, the next state is WRITE.
REQ-025 READ: MemRead=1 and Address=src+i; readData is captured into a data register at the clock edge; the next state is WRITE.
REQ-026 WRITE: MemWrite=1, Address=dst+i, and writeData=data register (copy) or FillValue (fill); i increments.
REQ-027 After WRITE, the next state is FIN if i+1=Length; otherwise it is READ (copy) or WRITE (fill).
REQ-028 FIN: Done=1 for exactly one cycle; the next state is IDLE.
REQ-029 Copy proceeds in ascending address order only; when regions overlap with dst>src, the result is the defined forward-copy smear.
REQ-030 Latency, with Start sampled at edge k: Done is high in cycle k+1+2·Length (copy), k+1+Length (fill), or k+1 (Length=0).
REQ-031 Start is ignored whenever Busy=1; latched operands are never modified mid-transfer.
REQ-032 MemRead and MemWrite are never high in the same cycle.
REQ-033 When the memory is not being accessed, Address=0, writeData=0, MemRead=0 and MemWrite=0.

Reset
REQ-034 While RST=1, the state is IDLE, all outputs are 0, and i, the data register and the latched operands are 0.
REQ-035 RST asserted mid-transfer aborts the transfer at the same edge: no further write occurs, and Done and Error are not pulsed.
REQ-036 RST has priority over Start in the same cycle.

Structure
REQ-037 Shared package dmem_pkg holds the state enum, the Mode encodings (MODE_COPY, MODE_FILL) and the DEPTH default, for reuse with the data memory.
REQ-038 The block is a single module with no sub-modules; the FSM, index counter and data register are all inline.

Verification
REQ-039 After reset, memory holds mem[i]=i and mem[16+i]=-i; copy Src=0, Dst=20, Len=4 -> mem[20..23]=0,1,2,3, Done in cycle k+9, 8 alternating READ/WRITE cycles.
REQ-040 Fill Dst=8, Len=3, FillValue=0xAA -> mem[8..10]=0xAA, mem[11]=11, Done in cycle k+4, MemRead never asserted.
REQ-041 Start with Len=0 -> Done in cycle k+1, and MemRead=MemWrite=0 throughout.
REQ-042 Copy Src=30, Len=4 -> Error pulse in cycle k+1, no memory access, Busy stays 0.
REQ-043 A second Start during a copy with Src=16, Dst=0, Len=2 is ignored -> mem[0]=0x00, mem[1]=0xFF, and Done pulses once.
REQ-044 RST asserted in the 3rd cycle of a copy with Len=4 -> only 1 byte written, Done is never pulsed, all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the DMA engine and the data memory it drives:
// FSM states, mode encodings, default memory depth and a range-check helper.
package dmem_pkg;

  localparam int DMEM_DEPTH = 32;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FIN
  } dma_state_e;

  // 9-bit sum so that base+len can reach past 255 without wrapping.
  function automatic logic regionFits(input logic [7:0] base,
                                      input logic [8:0] len,
                                      input logic [8:0] depth);
    return ({1'b0, base} + len) <= depth;
  endfunction

endpackage

// File: rtl/dmem_dma.sv
// Byte DMA engine for the data memory: copies a region (read/write per byte)
// or fills a region with a constant, one memory access per cycle.
module dmem_dma
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int LEN_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Mode,
  input  logic [7:0]       SrcAddr,
  input  logic [7:0]       DstAddr,
  input  logic [LEN_W-1:0] Length,
  input  logic [7:0]       FillValue,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [7:0]       Address,
  output logic [7:0]       writeData,
  input  logic [7:0]       readData,
  output logic             MemRead,
  output logic             MemWrite
);

  typedef logic [LEN_W-1:0] len_t;

  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] dst_q, dst_d;
  len_t       len_q, len_d;
  logic       mode_q, mode_d;
  logic [7:0] fill_q, fill_d;
  len_t       i_q, i_d;
  logic [7:0] data_q, data_d;
  logic       error_q, error_d;

  logic       busyC, doneC, memReadC, memWriteC;
  logic [7:0] addrC, wdataC;
  logic [8:0] reqLen9;
  logic       reqOk;
  logic       lastByte;

  assign reqLen9  = 9'(Length);
  assign reqOk    = regionFits(DstAddr, reqLen9, DEPTH9) &&
                    ((Mode == MODE_FILL) || regionFits(SrcAddr, reqLen9, DEPTH9));
  assign lastByte = ({1'b0, i_q} + (LEN_W+1)'(1)) == {1'b0, len_q};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      i_q     <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      i_q     <= i_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    i_d       = i_q;
    data_d    = data_q;
    error_d   = 1'b0;
    busyC     = 1'b1;
    doneC     = 1'b0;
    memReadC  = 1'b0;
    memWriteC = 1'b0;
    addrC     = '0;
    wdataC    = '0;

    unique case (state_q)
      ST_IDLE: begin
        busyC = 1'b0;
        if (Start) begin
          src_d  = SrcAddr;
          dst_d  = DstAddr;
          len_d  = Length;
          mode_d = Mode;
          fill_d = FillValue;
          i_d    = '0;
          if (!reqOk)
            error_d = 1'b1;
          else if (Length == '0)
            state_d = ST_FIN;
          else if (Mode == MODE_COPY)
            state_d = ST_READ;
          else
            state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        memReadC = 1'b1;
        addrC    = src_q + 8'(i_q);
        data_d   = readData;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        memWriteC = 1'b1;
        addrC     = dst_q + 8'(i_q);
        wdataC    = (mode_q == MODE_COPY) ? data_q : fill_q;
        i_d       = i_q + len_t'(1);
        if (lastByte)
          state_d = ST_FIN;
        else if (mode_q == MODE_COPY)
          state_d = ST_READ;
        else
          state_d = ST_WRITE;
      end
      ST_FIN: begin
        doneC   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset masks the outputs in the same cycle so a WRITE in flight cannot commit.
  assign Busy      = ~RST & busyC;
  assign Done      = ~RST & doneC;
  assign Error     = ~RST & error_q;
  assign MemRead   = ~RST & memReadC;
  assign MemWrite  = ~RST & memWriteC;
  assign Address   = RST ? 8'h00 : addrC;
  assign writeData = RST ? 8'h00 : wdataC;

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: a transaction-level model expands each
// request into the expected per-cycle bus activity and the expected memory image.
module tb_dmem_dma;
  import dmem_pkg::*;

  localparam int DEPTH = 32;
  localparam int LEN_W = 6;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Start;
  logic             Mode;
  logic [7:0]       SrcAddr;
  logic [7:0]       DstAddr;
  logic [LEN_W-1:0] Length;
  logic [7:0]       FillValue;
  logic             Busy, Done, Error, MemRead, MemWrite;
  logic [7:0]       Address, writeData, readData;

  logic [7:0] mem [DEPTH];
  logic       loadMem;

  dmem_dma #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
    .Busy(Busy), .Done(Done), .Error(Error), .Address(Address),
    .writeData(writeData), .readData(readData), .MemRead(MemRead), .MemWrite(MemWrite)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] initVal(input int a);
    return (a < 16) ? 8'(a) : 8'(-(a - 16));
  endfunction

  // Bench-side data memory: combinational read, write committed on the edge.
  always @(posedge CLK) begin
    if (loadMem) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= initVal(a);
    end else if (MemWrite && Address < DEPTH) begin
      mem[Address[4:0]] <= writeData;
    end
  end

  assign readData = (MemRead && Address < DEPTH) ? mem[Address[4:0]] : 8'h00;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       error;
    logic       mrd;
    logic       mwr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] expMem [DEPTH];

  int checks, errors;
  int doneCount, errCount, rdCycles, wrCycles;
  int lastDoneCycle, lastErrCycle, startEdge;

  function automatic exp_t mk(input logic b, input logic d, input logic e,
                              input logic r, input logic w,
                              input int a, input logic [7:0] wd);
    exp_t x;
    x.busy = b; x.done = d; x.error = e; x.mrd = r; x.mwr = w;
    x.addr = 8'(a); x.wdata = wd;
    return x;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Expands one request into the cycles that follow the Start cycle.
  task automatic modelOp(input logic mode, input int src, input int dst,
                         input int len, input logic [7:0] fill);
    logic [7:0] scratch [DEPTH];
    logic [7:0] v;
    scratch = expMem;
    expQ.push_back('0);
    if ((mode == MODE_COPY && src + len > DEPTH) || dst + len > DEPTH) begin
      expQ.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00));
    end else begin
      for (int j = 0; j < len; j++) begin
        if (mode == MODE_COPY) begin
          expQ.push_back(mk(1, 0, 0, 1, 0, src + j, 8'h00));
          v = scratch[src + j];
        end else begin
          v = fill;
        end
        scratch[dst + j] = v;
        expQ.push_back(mk(1, 0, 0, 0, 1, dst + j, v));
      end
      expQ.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00));
    end
  endtask

  task automatic compareCycle();
    exp_t e;
    e = '0;
    if (RST) expQ.delete();
    else if (expQ.size() > 0) e = expQ.pop_front();
    checks++;
    if ({Busy, Done, Error, MemRead, MemWrite} !== {e.busy, e.done, e.error, e.mrd, e.mwr} ||
        Address !== e.addr || (!e.mrd && writeData !== e.wdata)) begin
      errors++;
      $display("[TB] FAIL cycle %0d bus: got busy=%b done=%b err=%b rd=%b wr=%b addr=%0d wdata=%02h, expected busy=%b done=%b err=%b rd=%b wr=%b addr=%0d wdata=%02h",
               cyc + 1, Busy, Done, Error, MemRead, MemWrite, Address, writeData,
               e.busy, e.done, e.error, e.mrd, e.mwr, e.addr, e.wdata);
    end
    if (e.mwr) expMem[e.addr[4:0]] = e.wdata;
    if (Done) begin doneCount++; lastDoneCycle = cyc + 1; end
    if (Error) begin errCount++; lastErrCycle = cyc + 1; end
    if (MemRead) rdCycles++;
    if (MemWrite) wrCycles++;
  endtask

  task automatic applyStimulus(input logic mode, input int src, input int dst,
                               input int len, input logic [7:0] fill);
    @(posedge CLK); #1;
    Mode = mode; SrcAddr = 8'(src); DstAddr = 8'(dst);
    Length = LEN_W'(len); FillValue = fill; Start = 1'b1;
    startEdge = cyc + 1;
    modelOp(mode, src, dst, len, fill);
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    checkOutput("transfer timeout (pending cycles)", expQ.size(), 0);
    expQ.delete();
    @(posedge CLK); #1;
  endtask

  task automatic checkMem(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== expMem[a]) bad++;
    checkOutput({name, " memory words differing from model"}, bad, 0);
  endtask

  initial begin
    int d0, e0, r0, w0;
    RST = 1'b1; loadMem = 1'b1; Start = 1'b0; Mode = MODE_COPY;
    SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
    checks = 0; errors = 0; doneCount = 0; errCount = 0;
    rdCycles = 0; wrCycles = 0; lastDoneCycle = 0; lastErrCycle = 0; startEdge = 0;
    for (int a = 0; a < DEPTH; a++) expMem[a] = initVal(a);

    fork
      forever begin
        @(negedge CLK);
        compareCycle();
      end
    join_none

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset Busy", Busy, 0);
    checkOutput("reset Address", Address, 0);
    checkOutput("init mem[17]", mem[17], 8'hFF);
    RST = 1'b0; loadMem = 1'b0;

    // Copy 0 -> 20, four bytes
    d0 = doneCount; r0 = rdCycles; w0 = wrCycles;
    applyStimulus(MODE_COPY, 0, 20, 4, 8'h00);
    waitIdle();
    checkOutput("copy latency", lastDoneCycle - startEdge, 9);
    checkOutput("copy mem[20]", mem[20], 8'h00);
    checkOutput("copy mem[23]", mem[23], 8'h03);
    checkOutput("copy read cycles", rdCycles - r0, 4);
    checkOutput("copy write cycles", wrCycles - w0, 4);
    checkOutput("copy done pulses", doneCount - d0, 1);
    checkMem("copy");

    // Fill 8..10 with 0xAA
    r0 = rdCycles;
    applyStimulus(MODE_FILL, 0, 8, 3, 8'hAA);
    waitIdle();
    checkOutput("fill latency", lastDoneCycle - startEdge, 4);
    checkOutput("fill mem[8]", mem[8], 8'hAA);
    checkOutput("fill mem[10]", mem[10], 8'hAA);
    checkOutput("fill mem[11]", mem[11], 8'h0B);
    checkOutput("fill read cycles", rdCycles - r0, 0);
    checkMem("fill");

    // Zero length
    r0 = rdCycles; w0 = wrCycles;
    applyStimulus(MODE_COPY, 5, 6, 0, 8'h00);
    waitIdle();
    checkOutput("len0 latency", lastDoneCycle - startEdge, 1);
    checkOutput("len0 accesses", (rdCycles - r0) + (wrCycles - w0), 0);

    // Source overruns the memory
    d0 = doneCount; e0 = errCount; r0 = rdCycles; w0 = wrCycles;
    applyStimulus(MODE_COPY, 30, 0, 4, 8'h00);
    waitIdle();
    checkOutput("reject error pulses", errCount - e0, 1);
    checkOutput("reject error latency", lastErrCycle - startEdge, 1);
    checkOutput("reject done pulses", doneCount - d0, 0);
    checkOutput("reject accesses", (rdCycles - r0) + (wrCycles - w0), 0);
    checkMem("reject");

    // Destination ending exactly at DEPTH is legal; one past it is not
    d0 = doneCount;
    applyStimulus(MODE_FILL, 0, 28, 4, 8'h3C);
    waitIdle();
    checkOutput("edge fill mem[31]", mem[31], 8'h3C);
    checkOutput("edge fill done pulses", doneCount - d0, 1);
    e0 = errCount;
    applyStimulus(MODE_COPY, 0, 29, 4, 8'h00);
    waitIdle();
    checkOutput("edge copy error pulses", errCount - e0, 1);

    // A second Start while busy must be ignored
    d0 = doneCount;
    applyStimulus(MODE_COPY, 16, 0, 2, 8'h00);
    Mode = MODE_FILL; SrcAddr = 8'd0; DstAddr = 8'd4; Length = LEN_W'(3);
    FillValue = 8'h77; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    waitIdle();
    checkOutput("busy-start mem[0]", mem[0], 8'h00);
    checkOutput("busy-start mem[1]", mem[1], 8'hFF);
    checkOutput("busy-start mem[4]", mem[4], 8'h04);
    checkOutput("busy-start done pulses", doneCount - d0, 1);
    checkMem("busy-start");

    // Overlapping forward copy smears the first byte
    applyStimulus(MODE_COPY, 2, 3, 4, 8'h00);
    waitIdle();
    checkOutput("smear mem[6]", mem[6], 8'h02);
    checkMem("smear");

    // Reset in the third cycle of a four-byte copy
    d0 = doneCount; w0 = wrCycles;
    applyStimulus(MODE_COPY, 0, 24, 4, 8'h00);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    checkOutput("post-reset outputs", {Busy, Done, Error, MemRead, MemWrite, Address, writeData}, 0);
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("abort done pulses", doneCount - d0, 0);
    checkOutput("abort write cycles", wrCycles - w0, 1);
    checkOutput("abort mem[24]", mem[24], 8'h00);
    checkOutput("abort mem[25]", mem[25], 8'hF7);
    checkMem("abort");

    // Full-depth fill
    applyStimulus(MODE_FILL, 0, 0, 32, 8'h5A);
    waitIdle();
    checkOutput("full fill latency", lastDoneCycle - startEdge, 33);
    checkOutput("full fill mem[0]", mem[0], 8'h5A);
    checkOutput("full fill mem[31]", mem[31], 8'h5A);
    checkMem("full fill");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
